// File: rtl/rr_mux_collector_if.sv
// Handshake bundle for rr_mux_collector: per-source valid/ready/data inputs and
// the single registered output channel with its source index and arbiter pointer.
interface rr_mux_collector_if #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_SOURCES = 4
);
  localparam int SEL_W = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] in_valid;
  logic [BIT_WIDTH-1:0]   in_data [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] in_ready;
  logic                   out_valid;
  logic [BIT_WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_ready;
  logic [SEL_W-1:0]       rr_ptr;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, rr_ptr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, rr_ptr
  );
endinterface

// File: rtl/rr_mux_collector.sv
// Registered N-to-1 round-robin collector with valid/ready on every port.
// Define RR_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority (rr_ptr held at 0).
module rr_mux_collector #(
  parameter  int BIT_WIDTH   = 8,
  parameter  int NUM_SOURCES = 4,
  localparam int SEL_W       = $clog2(NUM_SOURCES)
) (
  input logic              clk,
  input logic              rst_n,
  rr_mux_collector_if.slave bus
);

  logic             free;
  logic             found;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] start;
  int               idx;

  assign free = !bus.out_valid || bus.out_ready;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign start = '0;
`else
  assign start = bus.rr_ptr;
`endif

  // Scan from the priority pointer with wrap; the first valid source wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_SOURCES)
        idx = idx - NUM_SOURCES;
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (found && free)
      bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.rr_ptr    <= '0;
    end else if (found && free) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[grant];
      bus.out_sel   <= grant;
`ifdef RR_MUX_FIXED_PRIO_EN
      bus.rr_ptr    <= '0;
`else
      bus.rr_ptr    <= (grant == SEL_W'(NUM_SOURCES - 1)) ? '0 : grant + SEL_W'(1);
`endif
    end else if (bus.out_ready) begin
      // Drain without refill keeps the last word and index visible.
      bus.out_valid <= 1'b0;
    end
  end

endmodule
